core_if_inst_queue: RTL and testbench

CORE_IF_INST_QUEUE -- requirements
Module: core_if_inst_queue

---
 rtl/core_if_inst_queue.sv | 99 +++++++++
 tb/tb_core_if_inst_queue.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/core_if_inst_queue.sv
`default_nettype none
// ============================================================================
// Module   : core_if_inst_queue
// Brief    : IFU->IDU instruction queue (circular buffer) with flush support;
//            define CORE_IF_IQ_BYPASS_EN for empty-queue pass-through.
// Revision : 1.0
// ============================================================================
module core_if_inst_queue #(
  parameter int DEPTH  = 4,
  parameter int INST_W = 32,
  parameter int PC_W   = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      valid_in,
  output logic                      ready_in,
  input  logic [INST_W-1:0]         i_inst,
  input  logic [PC_W-1:0]           i_pc,
  input  logic                      i_branch_predict,
  input  logic                      i_pipe_flush_req,
  output logic                      valid_out,
  input  logic                      ready_out,
  output logic [INST_W-1:0]         o_inst,
  output logic [PC_W-1:0]           o_pc,
  output logic                      o_branch_predict,
  output logic [$clog2(DEPTH):0]    o_count
);

  localparam int C_AW = $clog2(DEPTH);
  localparam int C_CW = C_AW + 1;
  localparam logic [C_CW-1:0] C_FULL = C_CW'(DEPTH);

  logic [INST_W-1:0] r_inst_mem [DEPTH];
  logic [PC_W-1:0]   r_pc_mem   [DEPTH];
  logic [DEPTH-1:0]  r_bp_mem;
  logic [C_AW-1:0]   r_wptr;
  logic [C_AW-1:0]   r_rptr;
  logic [C_CW-1:0]   r_count;

  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_empty  = (r_count == '0);
  assign ready_in = (r_count < C_FULL);
  assign o_count  = r_count;

`ifdef CORE_IF_IQ_BYPASS_EN
  logic w_bypass;

  // Empty queue forwards the upstream entry; it is stored only if IDU stalls.
  assign w_bypass         = w_empty && !i_pipe_flush_req;
  assign valid_out        = w_bypass ? valid_in : (!w_empty && !i_pipe_flush_req);
  assign o_inst           = w_bypass ? i_inst           : r_inst_mem[r_rptr];
  assign o_pc             = w_bypass ? i_pc             : r_pc_mem[r_rptr];
  assign o_branch_predict = w_bypass ? i_branch_predict : r_bp_mem[r_rptr];
  assign w_push           = valid_in && ready_in && !i_pipe_flush_req &&
                            !(w_bypass && ready_out);
`else
  assign valid_out        = !w_empty && !i_pipe_flush_req;
  assign o_inst           = r_inst_mem[r_rptr];
  assign o_pc             = r_pc_mem[r_rptr];
  assign o_branch_predict = r_bp_mem[r_rptr];
  assign w_push           = valid_in && ready_in && !i_pipe_flush_req;
`endif

  assign w_pop = valid_out && ready_out && !w_empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_inst_mem[r_wptr] <= i_inst;
      r_pc_mem[r_wptr]   <= i_pc;
      r_bp_mem[r_wptr]   <= i_branch_predict;
    end
  end

  // Reset outranks flush; both discard every queued entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_pipe_flush_req) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + C_AW'(1);
      if (w_pop)  r_rptr <= r_rptr + C_AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_CW'(1);
        2'b01:   r_count <= r_count - C_CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_core_if_inst_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_if_inst_queue
// Brief    : Directed stimulus with scoreboard/monitor for core_if_inst_queue.
// Revision : 1.0
// ============================================================================
module tb_core_if_inst_queue;

  localparam int DEPTH  = 4;
  localparam int INST_W = 32;
  localparam int PC_W   = 32;
`ifdef CORE_IF_IQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
    logic              bp;
  } entry_t;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 valid_in;
  logic                 ready_in;
  logic [INST_W-1:0]    i_inst;
  logic [PC_W-1:0]      i_pc;
  logic                 i_branch_predict;
  logic                 i_pipe_flush_req;
  logic                 valid_out;
  logic                 ready_out;
  logic [INST_W-1:0]    o_inst;
  logic [PC_W-1:0]      o_pc;
  logic                 o_branch_predict;
  logic [$clog2(DEPTH):0] o_count;

  core_if_inst_queue #(.DEPTH(DEPTH), .INST_W(INST_W), .PC_W(PC_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .valid_in         (valid_in),
    .ready_in         (ready_in),
    .i_inst           (i_inst),
    .i_pc             (i_pc),
    .i_branch_predict (i_branch_predict),
    .i_pipe_flush_req (i_pipe_flush_req),
    .valid_out        (valid_out),
    .ready_out        (ready_out),
    .o_inst           (o_inst),
    .o_pc             (o_pc),
    .o_branch_predict (o_branch_predict),
    .o_count          (o_count)
  );

  always #5 clk = ~clk;

  entry_t exp_q[$];
  int     n_checks = 0;
  int     n_errors = 0;
  int     m_count  = 0;
  bit     mon_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [INST_W-1:0] mk_inst(input logic [PC_W-1:0] pc);
    return {pc[15:0], ~pc[15:0]};
  endfunction

  // Drive one cycle; record the entry as expected output if the queue takes it.
  task automatic step(input bit rn, input bit v, input logic [PC_W-1:0] pc,
                      input bit rdy, input bit fl);
    entry_t e;
    @(posedge clk);
    #1;
    rst_n            = rn;
    valid_in         = v;
    i_pc             = pc;
    i_inst           = mk_inst(pc);
    i_branch_predict = pc[2] ^ pc[4];
    ready_out        = rdy;
    i_pipe_flush_req = fl;
    if (rn && v && !fl && (m_count < DEPTH)) begin
      e.inst = i_inst;
      e.pc   = i_pc;
      e.bp   = i_branch_predict;
      exp_q.push_back(e);
    end
  endtask

  // Monitor: reference occupancy model plus in-order data checking on every pop.
  always @(negedge clk) begin : mon
    bit     exp_vout;
    bit     do_push;
    bit     do_pop;
    entry_t e;
    if (mon_en) begin
      exp_vout = !i_pipe_flush_req && ((m_count != 0) || (BYP && valid_in));
      check("o_count", 64'(o_count), 64'(m_count));
      check("ready_in", 64'(ready_in), 64'(m_count < DEPTH));
      check("valid_out", 64'(valid_out), 64'(exp_vout));
      do_pop = rst_n && exp_vout && ready_out;
      if (do_pop) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL pop_unexpected: got pc 0x%0h required no entry at %0t", o_pc, $time);
        end else begin
          e = exp_q.pop_front();
          check("o_pc", 64'(o_pc), 64'(e.pc));
          check("o_inst", 64'(o_inst), 64'(e.inst));
          check("o_branch_predict", 64'(o_branch_predict), 64'(e.bp));
        end
      end
      do_push = valid_in && (m_count < DEPTH) && !(BYP && m_count == 0 && ready_out);
      if (!rst_n || i_pipe_flush_req) begin
        m_count = 0;
        exp_q.delete();
      end else begin
        m_count = m_count + (do_push ? 1 : 0) - ((do_pop && m_count != 0) ? 1 : 0);
      end
    end
  end

  initial begin
    rst_n = 1'b0; valid_in = 1'b0; i_pc = '0; i_inst = '0; i_branch_predict = 1'b0;
    ready_out = 1'b0; i_pipe_flush_req = 1'b0;

    step(0, 0, 0, 0, 0);
    mon_en = 1'b1;
    step(0, 0, 0, 0, 0);
    @(negedge clk);
    check("reset_count", 64'(o_count), 64'd0);
    check("reset_ready_in", 64'(ready_in), 64'd1);

    // Fill to DEPTH with IDU stalled; fifth entry is held off.
    for (int i = 0; i < 4; i++) step(1, 1, 32'h1000 + 32'(4 * i), 0, 0);
    step(1, 1, 32'h1010, 0, 0);
    @(negedge clk);
    check("full_count", 64'(o_count), 64'd4);
    check("full_ready_in", 64'(ready_in), 64'd0);

    // Pop while full: no push that cycle.
    step(1, 1, 32'h1010, 1, 0);
    step(1, 1, 32'h1010, 0, 0);
    @(negedge clk);
    check("after_pop_count", 64'(o_count), 64'd3);
    check("after_pop_pc", 64'(o_pc), 64'h1004);

    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);

    // Steady stream at occupancy 2 with pointer wrap.
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 32'h1100 + 32'(4 * i), 1, 0);
      if (i == 7) begin
        @(negedge clk);
        check("stream_count", 64'(o_count), 64'd2);
      end
    end

    // Flush with occupancy 3; 0x2000 must be dropped.
    step(1, 1, 32'h1200, 0, 0);
    step(1, 1, 32'h2000, 1, 1);
    @(negedge clk);
    check("flush_valid_out", 64'(valid_out), 64'd0);
    step(1, 0, 0, 0, 0);
    @(negedge clk);
    check("post_flush_count", 64'(o_count), 64'd0);

    // Empty-queue entry: bypassed or one-cycle latency depending on build.
    step(1, 1, 32'h3000, 1, 0);
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0);
    @(negedge clk);
    check("post_3000_count", 64'(o_count), 64'd0);

    // Reset mid-operation outranks a concurrent push and pop.
    step(1, 1, 32'h4000, 0, 0);
    step(1, 1, 32'h4004, 0, 0);
    step(0, 1, 32'h4008, 1, 0);
    @(negedge clk);
    check("pre_reset_count", 64'(o_count), 64'd2);
    step(1, 0, 0, 0, 0);
    @(negedge clk);
    check("mid_reset_count", 64'(o_count), 64'd0);
    check("mid_reset_valid_out", 64'(valid_out), 64'd0);
    check("mid_reset_ready_in", 64'(ready_in), 64'd1);

    // Mixed traffic, then drain.
    for (int i = 0; i < 12; i++)
      step(1, (i % 3) != 0, 32'h5000 + 32'(4 * i), (i % 2) == 1, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0);
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d entries outstanding required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
